player_state_mailbox: RTL
=========================

// Module: player_state_mailbox
// PURPOSE
//  N-slot mailbox for remote kart state on the 65 MHz game/pixel domain. Takes per-player state
//  words (already CDC'd from the eth domain) tagged with a player ID and keeps the latest per slot.
//  Publishes a tear-free snapshot of all slots once per frame to game/graphics. Tracks per-slot
//  link liveness by timeout. Generalises the single-opponent 45-bit receive buffer to NUM_PLAYERS.
// PARAMETERS
//  NUM_PLAYERS  4          player slots; ID_W = $clog2(NUM_PLAYERS), min 1
//  STATE_W      44         state word {x[10:0],pad,y[10:0],pad,dir[8:0],pad,game[2:0],pad,rst,pad}
//  TIMEOUT_CYC  6_500_000  cycles without accepted write before slot is dead (100 ms @ 65 MHz)
//  SEQ_W        8          sequence number width (used only with PSM_SEQ_CHECK_EN)
//  CNT_W        16         statistics counter width
// PORTS
//  clk_in        in   1                    pixel/game clock (65 MHz)
//  rst_in_n      in   1                    asynchronous, active-low reset
//  in_valid      in   1                    one-cycle strobe: in_id/in_data/in_seq valid
//  in_id         in   ID_W                 destination slot
//  in_data       in   STATE_W              player state word
//  in_seq        in   SEQ_W                packet sequence number (ignored unless PSM_SEQ_CHECK_EN)
//  frame_tick    in   1                    1-cycle strobe at frame start (hcount==0 && vcount==0)
//  snap_valid    out  1                    1-cycle pulse: snapshot outputs updated
//  snap_data     out  NUM_PLAYERS*STATE_W  snapshot; slot i at [i*STATE_W +: STATE_W]
//  snap_alive    out  NUM_PLAYERS          per-slot liveness at snapshot time
//  snap_fresh    out  NUM_PLAYERS          slot accepted >=1 write since previous snapshot
//  rx_cnt        out  CNT_W                accepted writes, saturating
//  drop_cnt      out  CNT_W                rejected writes (bad ID or stale seq), saturating
// BEHAVIOUR
//  Reset (async assert, sync deassert by upstream): all outputs 0; shadow, snapshot, seen,
//   fresh, ages, last_seq all 0. rst_in_n low mid-packet: packet lost, no partial state.
//  Accept: in_valid && in_id<NUM_PLAYERS (&& seq pass) -> next edge shadow[id]<=in_data,
//   seen[id]<=1, age[id]<=0, fresh_acc[id]<=1, rx_cnt+1. in_id>=NUM_PLAYERS -> drop_cnt+1, no write.
//  Age: per slot, +1 each cycle when no accept, saturates at TIMEOUT_CYC.
//   alive[i] = seen[i] && age[i] < TIMEOUT_CYC. Age reaching TIMEOUT_CYC clears seen[i]; data kept.
//  Snapshot: frame_tick at cycle T -> at T+1 snap_data<=shadow, snap_alive<=alive,
//   snap_fresh<=fresh_acc, snap_valid=1 for exactly that cycle; fresh_acc cleared at T+1.
//   Simultaneous accept to slot i and frame_tick at T: new in_data forwarded into snap_data[i],
//   snap_alive[i]=1, snap_fresh[i]=1; fresh_acc[i] ends 0. Outputs hold between snapshots.
//  frame_tick on consecutive cycles: each produces a snapshot (no suppression).
//  Counters: saturate at all-ones, never wrap. One event per cycle max (one input port).
// CONFIGURATION
//  PSM_SEQ_CHECK_EN defined: per-slot last_seq. Accept only if slot not seen, or
//   d=(in_seq-last_seq[id]) mod 2^SEQ_W is in [1, 2^(SEQ_W-1)-1]; else drop_cnt+1, no write.
//   On accept last_seq[id]<=in_seq. Timeout clears seen, so first packet after timeout accepted.
//  Undefined: in_seq ignored, no last_seq storage; every in-range ID accepted (dupes overwrite).
// STRUCTURE
//  psm_pkg: player_state_t packed struct (x,y,dir,game,rst fields, padding positions fixed),
//   STATE_W localparam derived from it, field offset constants shared with transmit/game.
//  Sub-module psm_slot_ager: one per slot via generate; ports clk_in, rst_in_n, accept, alive;
//   owns age counter ($clog2(TIMEOUT_CYC+1) bits) and seen flag.
// TESTING (TIMEOUT_CYC=100 for sim, NUM_PLAYERS=4)
//  write id=2 data=0xABC, frame_tick 5 cycles later -> snap_valid 1 cycle after tick,
//   slot2=0xABC, snap_alive=4'b0100, snap_fresh=4'b0100, rx_cnt=1
//  same-cycle write id=1 data=0x55 + frame_tick -> next cycle slot1=0x55, fresh bit1=1;
//   next tick with no writes -> snap_fresh=0, slot1 still 0x55
//  write id=0 then idle 100 cycles, frame_tick -> snap_alive[0]=0, slot0 data retained
//  NUM_PLAYERS=3, write id=3 -> drop_cnt=1, rx_cnt unchanged, no slot altered
//  PSM_SEQ_CHECK_EN: id=0 seq 10,11,11,9,200 -> accept,accept,drop,drop,drop; seq 255 then 0 -> both accepted
//  force drop_cnt to 0xFFFE, three bad IDs -> 0xFFFF holds; assert rst_in_n low mid-stream ->
//   all outputs 0 immediately, no snap_valid until next frame_tick after release

Source files
------------

// File: rtl/psm_pkg.sv
// psm_pkg: types and constants shared by the player state mailbox, the
// transmit path and the game logic.
//
// player_state_t fixes the on-wire layout of one 44-bit kart state word, MSB first:
//   x[10:0], pad, y[10:0], pad, dir[8:0], pad[2:0], game[2:0], pad, rst, pad[2:0]
// The padding positions are fixed so that every consumer agrees on bit offsets.
// The *_LSB constants give the field positions inside the flat word.
package psm_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic        pad0;
        logic [10:0] y;
        logic        pad1;
        logic [8:0]  dir;
        logic [2:0]  pad2;
        logic [2:0]  game;
        logic        pad3;
        logic        rst;
        logic [2:0]  pad4;
    } player_state_t;

    localparam int PSM_STATE_W = $bits(player_state_t);

    // Field offsets inside the flat state word
    localparam int X_LSB    = 33;
    localparam int X_W      = 11;
    localparam int Y_LSB    = 21;
    localparam int Y_W      = 11;
    localparam int DIR_LSB  = 11;
    localparam int DIR_W    = 9;
    localparam int GAME_LSB = 5;
    localparam int GAME_W   = 3;
    localparam int RST_BIT  = 3;

    // Default build parameters
    localparam int DEF_NUM_PLAYERS = 4;
    localparam int DEF_TIMEOUT_CYC = 6_500_000;
    localparam int DEF_SEQ_W       = 8;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/psm_slot_ager.sv
// psm_slot_ager: liveness tracker for one mailbox slot.
//
// Ports:
//   clk_in    in   game/pixel clock
//   rst_in_n  in   asynchronous active-low reset
//   accept    in   a write to this slot is accepted this cycle
//   alive     out  slot has been written and has not timed out
//
// The age counter restarts on every accepted write and saturates at
// TIMEOUT_CYC. Reaching TIMEOUT_CYC clears the seen flag, so the slot reads
// dead until the next accepted write.
module psm_slot_ager
    import psm_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic accept,
    output logic alive
);

    localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYC);

    logic [AGE_W-1:0] age_q, age_d;
    logic             seen_q, seen_d;

    always_comb begin
        age_d  = age_q;
        seen_d = seen_q;
        if (accept) begin
            age_d  = '0;
            seen_d = 1'b1;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
            if (age_d == AGE_MAX) begin
                seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            age_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            seen_q <= seen_d;
        end
    end

    assign alive = seen_q && (age_q != AGE_MAX);

endmodule

// File: rtl/player_state_mailbox.sv
// player_state_mailbox: N-slot mailbox for remote kart state in the game/pixel
// clock domain. Keeps the latest state word per player slot, publishes a
// tear-free snapshot of every slot once per frame and tracks per-slot link
// liveness by timeout.
//
// Ports:
//   clk_in      in   game/pixel clock
//   rst_in_n    in   asynchronous active-low reset
//   in_valid    in   one-cycle strobe, in_id/in_data/in_seq valid
//   in_id       in   destination slot
//   in_data     in   player state word
//   in_seq      in   packet sequence number
//   frame_tick  in   one-cycle strobe at frame start
//   snap_valid  out  one-cycle pulse when snapshot outputs update
//   snap_data   out  snapshot, slot i at [i*STATE_W +: STATE_W]
//   snap_alive  out  per-slot liveness at snapshot time
//   snap_fresh  out  slot accepted a write since the previous snapshot
//   rx_cnt      out  accepted writes, saturating
//   drop_cnt    out  rejected writes, saturating
//
// Optional feature: define PSM_SEQ_CHECK_EN to keep a per-slot last sequence
// number and reject stale or duplicate packets. Without it in_seq is ignored
// and every in-range ID is accepted.
module player_state_mailbox
    import psm_pkg::*;
#(
    parameter  int NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter  int STATE_W     = PSM_STATE_W,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter  int SEQ_W       = DEF_SEQ_W,
    parameter  int CNT_W       = DEF_CNT_W,
    localparam int ID_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in_n,
    input  logic                           in_valid,
    input  logic [ID_W-1:0]                in_id,
    input  logic [STATE_W-1:0]             in_data,
    input  logic [SEQ_W-1:0]               in_seq,
    input  logic                           frame_tick,
    output logic                           snap_valid,
    output logic [NUM_PLAYERS*STATE_W-1:0] snap_data,
    output logic [NUM_PLAYERS-1:0]         snap_alive,
    output logic [NUM_PLAYERS-1:0]         snap_fresh,
    output logic [CNT_W-1:0]               rx_cnt,
    output logic [CNT_W-1:0]               drop_cnt
);

    logic [NUM_PLAYERS-1:0][STATE_W-1:0] shadow_q, shadow_d;
    logic [NUM_PLAYERS-1:0][STATE_W-1:0] snap_data_q, snap_data_d;
    logic [NUM_PLAYERS-1:0]              snap_alive_q, snap_alive_d;
    logic [NUM_PLAYERS-1:0]              snap_fresh_q, snap_fresh_d;
    logic                                snap_valid_q, snap_valid_d;
    logic [NUM_PLAYERS-1:0]              fresh_q, fresh_d;
    logic [CNT_W-1:0]                    rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]                    drop_cnt_q, drop_cnt_d;

    logic [NUM_PLAYERS-1:0] alive;
    logic [NUM_PLAYERS-1:0] accept_vec;
    logic                   id_ok;
    logic                   seq_ok;
    logic                   accept;
    logic                   drop;

    // The ager's alive flag doubles as the "seen" flag for sequence checking,
    // since a slot stops being seen exactly when it times out.
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_slot
        psm_slot_ager #(
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_ager (
            .clk_in  (clk_in),
            .rst_in_n(rst_in_n),
            .accept  (accept_vec[g]),
            .alive   (alive[g])
        );
    end

`ifdef PSM_SEQ_CHECK_EN
    logic [NUM_PLAYERS-1:0][SEQ_W-1:0] last_seq_q, last_seq_d;
    logic [SEQ_W-1:0]                  seq_last;
    logic [SEQ_W-1:0]                  seq_delta;
    logic                              seen_sel;

    // Serial-number comparison: a packet is newer when the modular distance
    // from the last accepted number is in the forward half-window. An unseen
    // (never written or timed out) slot takes any number.
    always_comb begin
        seq_last = '0;
        seen_sel = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (in_id == ID_W'(i)) begin
                seq_last = last_seq_q[i];
                seen_sel = alive[i];
            end
        end
        seq_delta = in_seq - seq_last;
        seq_ok    = !seen_sel || ((seq_delta != '0) && !seq_delta[SEQ_W-1]);
        last_seq_d = last_seq_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (accept_vec[i]) begin
                last_seq_d[i] = in_seq;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            last_seq_q <= '0;
        end else begin
            last_seq_q <= last_seq_d;
        end
    end
`else
    logic unused_seq;
    assign unused_seq = ^in_seq;
    assign seq_ok     = 1'b1;
`endif

    // Accept/drop decode. Only one input port exists, so at most one counter
    // event happens per cycle.
    always_comb begin
        id_ok  = (32'(in_id) < NUM_PLAYERS);
        accept = in_valid && id_ok && seq_ok;
        drop   = in_valid && !(id_ok && seq_ok);
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            accept_vec[i] = accept && (in_id == ID_W'(i));
        end
    end

    // Shadow, freshness and snapshot. The snapshot is taken from the next-state
    // shadow so a write landing in the tick cycle is forwarded into the
    // snapshot; its fresh bit goes into the snapshot and the accumulator ends
    // cleared.
    always_comb begin
        shadow_d     = shadow_q;
        snap_data_d  = snap_data_q;
        snap_alive_d = snap_alive_q;
        snap_fresh_d = snap_fresh_q;
        snap_valid_d = frame_tick;
        fresh_d      = fresh_q | accept_vec;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (accept_vec[i]) begin
                shadow_d[i] = in_data;
            end
        end
        if (frame_tick) begin
            snap_data_d  = shadow_d;
            snap_alive_d = alive | accept_vec;
            snap_fresh_d = fresh_q | accept_vec;
            fresh_d      = '0;
        end
    end

    // Saturating statistics counters
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (accept && (rx_cnt_q != '1)) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            shadow_q     <= '0;
            snap_data_q  <= '0;
            snap_alive_q <= '0;
            snap_fresh_q <= '0;
            snap_valid_q <= 1'b0;
            fresh_q      <= '0;
            rx_cnt_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            shadow_q     <= shadow_d;
            snap_data_q  <= snap_data_d;
            snap_alive_q <= snap_alive_d;
            snap_fresh_q <= snap_fresh_d;
            snap_valid_q <= snap_valid_d;
            fresh_q      <= fresh_d;
            rx_cnt_q     <= rx_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_data  = snap_data_q;
    assign snap_alive = snap_alive_q;
    assign snap_fresh = snap_fresh_q;
    assign rx_cnt     = rx_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
